matmult_mem_server: RTL
=======================

// Module: matmult_mem_server
// PURPOSE
//  Memory-side responder for matmult_kernel. Host loads A/B row vectors, then pulses Go.
//  Block pulses Start, serves kernel reads (Rd_en/Rd_A_addr/Rd_B_addr) with 1-cycle registered data,
//  and captures kernel writes (Wr_en/Wr_addr/C) into a result RAM. After NROWS writes it streams
//  results to the host over a valid/ready port. Sits between host/testbench and the kernel.
// PARAMETERS
//  INPUTWIDTH    8   signed element width of A/B lanes
//  OUTPUTWIDTH   20  result width; must be >= 2*INPUTWIDTH+4
//  INADDRWIDTH   8   A/B row address width
//  OUTADDRWIDTH  8   result address width
//  NROWS         64  rows per run; must be <= 2**INADDRWIDTH and <= 2**OUTADDRWIDTH
//  LANES         16  elements per row; fixed by the kernel
// PORTS
//  Clk        in   1                    single clock; all logic on posedge
//  Rst        in   1                    synchronous, active-high reset
//  Ld_valid   in   1                    host load strobe
//  Ld_ready   out  1                    high only in IDLE
//  Ld_sel     in   1                    0 = A bank, 1 = B bank
//  Ld_addr    in   INADDRWIDTH          row address
//  Ld_data    in   LANES*INPUTWIDTH     packed row; lane i = bits [i*W +: W]
//  Go         in   1                    run request; sampled only in IDLE
//  Start      out  1                    1-cycle pulse to kernel
//  Rd_en      in   1                    kernel read enable
//  Rd_A_addr  in   INADDRWIDTH          kernel A row address
//  Rd_B_addr  in   INADDRWIDTH          kernel B row address
//  A_flat     out  LANES*INPUTWIDTH     A row; top level splits into A_0..A_15
//  B_flat     out  LANES*INPUTWIDTH     B row; top level splits into B_0..B_15
//  Wr_en      in   1                    kernel result write enable
//  Wr_addr    in   OUTADDRWIDTH         kernel result address
//  C          in   OUTPUTWIDTH          kernel result
//  Res_valid  out  1                    result stream valid
//  Res_ready  in   1                    result stream ready
//  Res_addr   out  OUTADDRWIDTH         index of Res_data
//  Res_data   out  OUTPUTWIDTH          result value
//  Done       out  1                    1-cycle pulse after the last result transfer
//  Err        out  1                    sticky: out-of-range Wr_addr seen; cleared by Rst or Go
// BEHAVIOUR
//  Reset: state = IDLE.
//   - Outputs after reset: Start=0, Res_valid=0, Done=0, Err=0, A_flat=B_flat=0, Res_addr=0,
//     Ld_ready=1 from the next cycle.
//   - RAM contents are not cleared.
//  FSM IDLE -> RUN -> DRAIN -> IDLE.
//   - IDLE: Ld_valid writes Ld_data to bank[Ld_sel][Ld_addr].
//   - IDLE, Go=1: enter RUN, Start=1 for exactly one cycle, clear wr_cnt and Err.
//   - IDLE, Go and Ld_valid in the same cycle: the load completes, then RUN starts.
//  RUN:
//   - Rd_en=1 at cycle t: A_flat/B_flat at t+1 hold bank A[Rd_A_addr] and bank B[Rd_B_addr].
//   - Rd_en=0: flat outputs hold their last value.
//   - Read address >= NROWS returns all zeros.
//   - Wr_en=1 with Wr_addr < NROWS: write C to res[Wr_addr]; wr_cnt++.
//   - Wr_en=1 with Wr_addr >= NROWS: write dropped, Err=1, wr_cnt unchanged.
//   - A duplicate Wr_addr overwrites the entry and still counts.
//   - wr_cnt == NROWS: enter DRAIN.
//   - Go and Ld_valid are ignored in RUN.
//  DRAIN:
//   - Results go out in order, addresses 0..NROWS-1. RAM read latency 1; data is prefetched so
//     Res_valid is continuous when Res_ready=1.
//   - Once Res_valid=1, Res_valid/Res_addr/Res_data stay stable until Res_valid & Res_ready.
//   - Transfer of index NROWS-1: the next cycle Done=1, Res_valid=0, state = IDLE.
//   - Kernel writes arriving in DRAIN are ignored.
//  Rst mid-RUN or mid-DRAIN: IDLE next cycle; counters and valid outputs cleared.
//  Arithmetic: no computation. wr_cnt and drain index are $clog2(NROWS+1) bits wide;
//   lane order is preserved bit-exactly.
// STRUCTURE
//  define.v holds widths, LANES, NROWS and the state encodings (S_IDLE/S_RUN/S_DRAIN).
//  Sub-module matmult_bank_ram: simple dual-port RAM (1 write, 1 registered read, parameterised
//   width/depth). Three instances: A, B, result.
//  Top level contains the FSM, counters, range checks and drain prefetch.
// TESTING
//  1 Rst mid-stream, then idle -> all outputs 0; Ld_ready=1 the next cycle.
//  2 Load A[r] lanes = r+i and B[r] lanes = 1; Go; Rd_en addr 5 at t -> A_flat lane3 = 8,
//    B_flat lane3 = 1 at t+1.
//  3 With a matmult_kernel attached (NROWS=64): results stream 0..63, res[r] = 16r+120,
//    then one Done pulse.
//  4 Res_ready toggles 1,0,0,1 during DRAIN -> data held stable while stalled;
//    no index skipped or repeated.
//  5 Wr_en with Wr_addr=70 (NROWS=64) -> Err=1, no RAM write, wr_cnt unchanged;
//    a second Go clears Err.
//  6 Rst asserted in RUN after 10 writes -> IDLE, Start=0; new Go runs a full 64-row pass cleanly.

Source files
------------

// File: rtl/matmult_mem_server_pkg.sv
// Shared types and helpers for the matmult memory server.
package matmult_mem_server_pkg;

  // Elements per row; fixed by the kernel datapath.
  localparam int LANES = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Address bits needed to index a RAM of the given depth (at least one).
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/matmult_mem_server_bank_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register holds its value when no read is issued, and can be
// forced to zero for reads the caller knows are out of range.
module matmult_mem_server_bank_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic          i_rzero,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  // Storage write; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read, held between reads, cleared by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= i_rzero ? '0 : r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/matmult_mem_server.sv
// Memory-side responder for matmult_kernel: host loads A/B rows, the kernel
// reads rows and writes NROWS results, then results stream out valid/ready.
module matmult_mem_server
  import matmult_mem_server_pkg::*;
#(
  parameter int INPUTWIDTH   = 8,
  parameter int OUTPUTWIDTH  = 20,
  parameter int INADDRWIDTH  = 8,
  parameter int OUTADDRWIDTH = 8,
  parameter int NROWS        = 64
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_ld_valid,
  output logic                          o_ld_ready,
  input  logic                          i_ld_sel,
  input  logic [INADDRWIDTH-1:0]        i_ld_addr,
  input  logic [LANES*INPUTWIDTH-1:0]   i_ld_data,
  input  logic                          i_go,
  output logic                          o_start,
  input  logic                          i_rd_en,
  input  logic [INADDRWIDTH-1:0]        i_rd_a_addr,
  input  logic [INADDRWIDTH-1:0]        i_rd_b_addr,
  output logic [LANES*INPUTWIDTH-1:0]   o_a_flat,
  output logic [LANES*INPUTWIDTH-1:0]   o_b_flat,
  input  logic                          i_wr_en,
  input  logic [OUTADDRWIDTH-1:0]       i_wr_addr,
  input  logic [OUTPUTWIDTH-1:0]        i_c,
  output logic                          o_res_valid,
  input  logic                          i_res_ready,
  output logic [OUTADDRWIDTH-1:0]       o_res_addr,
  output logic [OUTPUTWIDTH-1:0]        o_res_data,
  output logic                          o_done,
  output logic                          o_err
);

  localparam int DW  = LANES*INPUTWIDTH;
  localparam int RAW = addr_bits(NROWS);
  localparam int CW  = $clog2(NROWS+1);
  localparam logic [CW-1:0]           NR_CNT = CW'(NROWS);
  localparam logic [CW-1:0]           LAST   = CW'(NROWS-1);
  // One extra bit so NROWS == 2**width still compares correctly.
  localparam logic [INADDRWIDTH:0]    NR_IN  = (INADDRWIDTH+1)'(NROWS);
  localparam logic [OUTADDRWIDTH:0]   NR_OUT = (OUTADDRWIDTH+1)'(NROWS);

  state_t                  r_state, w_next;
  logic [CW-1:0]           r_wr_cnt;
  logic [CW-1:0]           r_issue;    // next result index to prefetch
  logic                    r_start, r_done, r_err, r_res_valid;
  logic [OUTADDRWIDTH-1:0] r_res_addr;

  logic w_idle, w_ld_ok, w_go, w_rd, w_a_zero, w_b_zero;
  logic w_wr_ok, w_wr_bad, w_adv, w_issue, w_last;

  assign w_idle   = (r_state == S_IDLE);
  assign w_ld_ok  = w_idle && i_ld_valid && ({1'b0, i_ld_addr} < NR_IN);
  assign w_go     = w_idle && i_go;
  assign w_rd     = (r_state == S_RUN) && i_rd_en;
  assign w_a_zero = ({1'b0, i_rd_a_addr} >= NR_IN);
  assign w_b_zero = ({1'b0, i_rd_b_addr} >= NR_IN);
  assign w_wr_ok  = (r_state == S_RUN) && i_wr_en && ({1'b0, i_wr_addr} < NR_OUT);
  assign w_wr_bad = (r_state == S_RUN) && i_wr_en && ({1'b0, i_wr_addr} >= NR_OUT);
  // Output slot can take a new entry when empty or being consumed.
  assign w_adv    = (r_state == S_DRAIN) && (!r_res_valid || i_res_ready);
  assign w_issue  = w_adv && (r_issue != NR_CNT);
  // All entries issued, so the one on the port is index NROWS-1.
  assign w_last   = (r_state == S_DRAIN) && r_res_valid && i_res_ready && (r_issue == NR_CNT);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state: leave RUN on the write that completes the row count.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_go) w_next = S_RUN;
      S_RUN:   if (w_wr_ok && (r_wr_cnt == LAST)) w_next = S_DRAIN;
      S_DRAIN: if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Counters, flags and the result output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_cnt    <= '0;
      r_issue     <= '0;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_addr  <= '0;
    end else begin
      r_start <= w_go;
      r_done  <= w_last;
      if (w_go) begin
        r_wr_cnt <= '0;
        r_issue  <= '0;
        r_err    <= 1'b0;
      end
      if (w_wr_ok)  r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_wr_bad) r_err    <= 1'b1;
      if (w_issue) begin
        r_issue     <= r_issue + 1'b1;
        r_res_valid <= 1'b1;
        r_res_addr  <= OUTADDRWIDTH'(r_issue);
      end else if (w_adv) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  matmult_mem_server_bank_ram #(.W(DW), .DEPTH(NROWS), .AW(RAW)) u_bank_a (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_we(w_ld_ok && !i_ld_sel), .i_waddr(i_ld_addr[RAW-1:0]), .i_wdata(i_ld_data),
    .i_re(w_rd), .i_rzero(w_a_zero), .i_raddr(i_rd_a_addr[RAW-1:0]), .o_rdata(o_a_flat)
  );

  matmult_mem_server_bank_ram #(.W(DW), .DEPTH(NROWS), .AW(RAW)) u_bank_b (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_we(w_ld_ok && i_ld_sel), .i_waddr(i_ld_addr[RAW-1:0]), .i_wdata(i_ld_data),
    .i_re(w_rd), .i_rzero(w_b_zero), .i_raddr(i_rd_b_addr[RAW-1:0]), .o_rdata(o_b_flat)
  );

  // Result RAM read register doubles as the Res_data output stage.
  matmult_mem_server_bank_ram #(.W(OUTPUTWIDTH), .DEPTH(NROWS), .AW(RAW)) u_bank_res (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_we(w_wr_ok), .i_waddr(i_wr_addr[RAW-1:0]), .i_wdata(i_c),
    .i_re(w_issue), .i_rzero(1'b0), .i_raddr(r_issue[RAW-1:0]), .o_rdata(o_res_data)
  );

  assign o_ld_ready  = w_idle;
  assign o_start     = r_start;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_res_valid = r_res_valid;
  assign o_res_addr  = r_res_addr;

endmodule
